batter_swing_judge: RTL and testbench
=====================================

Name: batter_swing_judge

Overview:
Produces the one-hot batter result {hit1,hit2,hit3,hit4,out} that drives the batter 7-segment decoder. It arbitrates a pitch window, debounces the raw swing button and draws a pseudo-random outcome from a free-running LFSR. It holds the result for display, then re-arms for the next pitch.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive synced-low samples required to accept a swing (>=1)
WINDOW_CYCLES, 2000, pitch window length in clocks; expiry without a swing gives out
HOLD_CYCLES, 1000, clocks the result is held on hitout
LFSR_SEED, 16'h0001, LFSR reset value (must be nonzero)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
swing_n  input  1  raw swing button, active low, asynchronous to clk
pitch_valid  input  1  one-cycle pulse: ball thrown, opens pitch window
hitout  output  5  one-hot result, bit4..0 = hit1,hit2,hit3,hit4,out; 0 = none
result_valid  output  1  one-cycle pulse on the first cycle hitout is nonzero
busy  output  1  high in PITCH and SHOW

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low, on rst_n. Reset values: hitout=0, result_valid=0, busy=0, FSM=IDLE, counters=0, LFSR=LFSR_SEED, synchronizer flops=1.
- Swing conditioning: 2-flop synchronizer on swing_n. Debounce counter increments while the synced value is 0, saturates at DEBOUNCE_CYCLES, and clears on 1. swing_evt is a single-cycle pulse in the cycle the counter reaches DEBOUNCE_CYCLES. A held button gives exactly one event; a new event needs release then re-press.
- LFSR: 16-bit Galois, right shift, taps 16'hB400. next = (l>>1) ^ (l[0] ? 16'hB400 : 0). Advances every clock from reset release, regardless of FSM state. With seed 1, the low nibble after steps 1..12 is 0,0,0,0,0,0,0,8,4,A,D,6.
- Outcome map, r = LFSR[3:0] in the swing_evt cycle: 0-6 out; 7-10 hit1; 11-12 hit2; 13 hit3; 14-15 hit4.
- FSM states IDLE, PITCH, SHOW:
  - IDLE: pitch_valid -> PITCH, window counter cleared. swing_evt is ignored (no effect).
  - PITCH: window counter increments each cycle.
    - swing_evt -> SHOW with the mapped result.
    - Counter reaching WINDOW_CYCLES-1 with no swing -> SHOW with out (strike).
    - swing_evt in the same cycle as expiry: the swing wins.
    - pitch_valid is ignored.
  - SHOW: hitout holds the result for exactly HOLD_CYCLES cycles, then -> IDLE with hitout=0. pitch_valid and swing_evt are ignored.
- Output timing: hitout and result_valid are registered. The result appears the cycle after swing_evt or expiry, and result_valid pulses in that same cycle. hitout is exactly one-hot in SHOW and all-zero otherwise, so the display shows blank when idle.
- busy = (state != IDLE), registered with the state.
- Reset mid-operation (any state): immediate return to reset values. A held button after reset release must go through a fresh debounce.
- Counters are sized by $clog2 of their parameter, with no wrap: all counters saturate or clear by state.

Test Plan:
- Reset, then 50 idle cycles -> hitout=0, busy=0, result_valid never asserted; LFSR low nibble matches the reference model (0,0,0,0,0,0,0,8,4,A,D,6 for seed 1).
- pitch_valid, no swing, WINDOW_CYCLES=20 -> hitout=5'b00001 appears 20 cycles after the PITCH entry cycle, result_valid pulses once, hitout is held HOLD_CYCLES cycles, then returns to 0 and busy=0.
- pitch_valid then swing_n held low 40 cycles (DEBOUNCE_CYCLES=16) -> exactly one swing_evt. hitout equals the bench-model map of LFSR[3:0] at the event cycle: r=8 -> 5'b10000, r=0xD -> 5'b00100, r=0xA -> 5'b10000, r=6 -> 5'b00001.
- Bounces: swing_n toggled low for 5 cycles at a time during PITCH (DEBOUNCE_CYCLES=16) -> no event; window expiry gives 5'b00001.
- Swing while IDLE or SHOW, and pitch_valid during PITCH or SHOW -> no state change, no extra result_valid. Swing event forced on the expiry cycle -> mapped result, not a forced out.
- rst_n pulsed low mid-SHOW and mid-PITCH -> hitout=0 and busy=0 immediately (asynchronous). The next pitch behaves normally.

Source files
------------

// File: rtl/batter_swing_judge.sv
// Purpose: batter outcome judge -- pitch window, debounced swing, LFSR-drawn one-hot result.
// Latency: result registered one clock after the debounced swing or window expiry.
// Backpressure: none; events outside the pitch window are dropped, the result is held for a fixed time.
module batter_swing_judge #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned WINDOW_CYCLES   = 2000,
    parameter int unsigned HOLD_CYCLES     = 1000,
    parameter logic [15:0] LFSR_SEED       = 16'h0001
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       swing_n,
    input  logic       pitch_valid,
    output logic [4:0] hitout,
    output logic       result_valid,
    output logic       busy
);

    // Counter widths: debounce must be able to hold DEBOUNCE_CYCLES itself,
    // window and hold only ever count up to their parameter minus one.
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int WIN_W  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    localparam logic [4:0]  RES_OUT  = 5'b00001;
    localparam logic [4:0]  RES_HIT1 = 5'b10000;
    localparam logic [4:0]  RES_HIT2 = 5'b01000;
    localparam logic [4:0]  RES_HIT3 = 5'b00100;
    localparam logic [4:0]  RES_HIT4 = 5'b00010;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PITCH = 2'd1,
        SHOW  = 2'd2
    } state_t;

    logic              sync1_q;
    logic              sync2_q;
    logic [DEB_W-1:0]  deb_q;
    logic [DEB_W-1:0]  deb_d;
    logic              swing_evt;
    logic [15:0]       lfsr_q;
    logic [15:0]       lfsr_d;
    state_t            state_q;
    logic [WIN_W-1:0]  win_q;
    logic [HOLD_W-1:0] hold_q;
    logic [4:0]        hitout_q;
    logic              result_valid_q;
    logic              busy_q;

    // Outcome table: low nibble of the LFSR picks the result, out is the most likely.
    function automatic logic [4:0] map_outcome(input logic [3:0] r);
        logic [4:0] res;
        if (r <= 4'd6)       res = RES_OUT;
        else if (r <= 4'd10) res = RES_HIT1;
        else if (r <= 4'd12) res = RES_HIT2;
        else if (r == 4'd13) res = RES_HIT3;
        else                 res = RES_HIT4;
        return res;
    endfunction

    // Two-flop synchronizer; idles high so a released button is the reset state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= swing_n;
            sync2_q <= sync1_q;
        end
    end

    // Debounce count: climbs while pressed, parks at the limit, clears on release.
    // The event fires only on the step onto the limit, so a held button fires once.
    always_comb begin
        deb_d = deb_q;
        if (sync2_q) begin
            deb_d = '0;
        end else if (deb_q != DEB_MAX) begin
            deb_d = deb_q + DEB_W'(1);
        end
        swing_evt = (deb_d == DEB_MAX) && (deb_q != DEB_MAX);
    end

    // Debounce counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) deb_q <= '0;
        else        deb_q <= deb_d;
    end

    // Galois right-shift LFSR next state.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    // Free-running LFSR, independent of the FSM so the draw depends on swing timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;
    end

    // Pitch FSM with registered result, valid pulse and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            win_q          <= '0;
            hold_q         <= '0;
            hitout_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pitch_valid) begin
                        state_q <= PITCH;
                        win_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                PITCH: begin
                    // Swing takes priority over a window expiry in the same cycle.
                    if (swing_evt) begin
                        state_q        <= SHOW;
                        hitout_q       <= map_outcome(lfsr_q[3:0]);
                        result_valid_q <= 1'b1;
                        hold_q         <= '0;
                    end else if (win_q == WIN_LAST) begin
                        state_q        <= SHOW;
                        hitout_q       <= RES_OUT;
                        result_valid_q <= 1'b1;
                        hold_q         <= '0;
                    end else begin
                        win_q <= win_q + WIN_W'(1);
                    end
                end
                SHOW: begin
                    if (hold_q == HOLD_LAST) begin
                        state_q  <= IDLE;
                        hitout_q <= '0;
                        busy_q   <= 1'b0;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    hitout_q <= '0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign hitout       = hitout_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_batter_swing_judge.sv
// Purpose: directed self-checking bench for batter_swing_judge with a result scoreboard.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: not applicable; the bench only drives pulses and button levels.
module tb_batter_swing_judge;

    localparam int          DEB  = 16;
    localparam int          WIN  = 20;
    localparam int          HOLD = 30;
    localparam logic [15:0] SEED = 16'h0001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       swing_n = 1'b1;
    logic       pitch_valid = 1'b0;
    logic [4:0] hitout;
    logic       result_valid;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int rv_seen = 0;
    int rv_expected = 0;

    logic [4:0]  sb[$];
    logic [15:0] lfsr_m;
    logic [3:0]  nib_tab [12];
    logic [4:0]  exp_res;

    batter_swing_judge #(
        .DEBOUNCE_CYCLES(DEB),
        .WINDOW_CYCLES(WIN),
        .HOLD_CYCLES(HOLD),
        .LFSR_SEED(SEED)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .swing_n(swing_n),
        .pitch_valid(pitch_valid),
        .hitout(hitout),
        .result_valid(result_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference LFSR from the polynomial definition.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_m <= SEED;
        else        lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    end

    function automatic logic [4:0] map_r(input logic [3:0] r);
        if (r <= 4'd6)       return 5'b00001;
        else if (r <= 4'd10) return 5'b10000;
        else if (r <= 4'd12) return 5'b01000;
        else if (r == 4'd13) return 5'b00100;
        else                 return 5'b00010;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] r);
        sb.push_back(r);
        rv_expected++;
    endtask

    // One clock step; any result_valid seen is popped against the scoreboard.
    task automatic step();
        logic [4:0] e;
        @(negedge clk);
        if (rst_n && result_valid) begin
            rv_seen++;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_result: hitout=%0h with empty scoreboard", hitout);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_hitout", 32'(hitout), 32'(e));
            end
        end
    endtask

    task automatic start_pitch();
        pitch_valid = 1'b1;
        step();
        pitch_valid = 1'b0;
        check("busy_pitch", 32'(busy), 32'd1);
    endtask

    // Expect the result on exactly the n-th rising edge from now.
    task automatic wait_result(input int n, input logic [4:0] exp);
        repeat (n - 1) step();
        check("rv_early", 32'(result_valid), 32'd0);
        step();
        check("rv_pulse", 32'(result_valid), 32'd1);
        check("hitout_res", 32'(hitout), 32'(exp));
    endtask

    // Press after 'a' cycles; predict from the reference LFSR in the event cycle.
    task automatic swing_result(input int a, output logic [4:0] exp);
        repeat (a) step();
        swing_n = 1'b0;
        repeat (DEB + 1) step();
        check("rv_before_evt", 32'(result_valid), 32'd0);
        exp = map_r(lfsr_m[3:0]);
        push(exp);
        step();
        check("rv_swing", 32'(result_valid), 32'd1);
        check("hitout_swing", 32'(hitout), 32'(exp));
    endtask

    // Called on the first result cycle; optionally disturbs SHOW with pitch and swing.
    task automatic hold_check(input logic [4:0] exp, input bit disturb);
        for (int i = 1; i < HOLD; i++) begin
            if (disturb && i == 5) pitch_valid = 1'b1;
            if (disturb && i == 6) pitch_valid = 1'b0;
            if (disturb && i == 8) swing_n = 1'b0;
            step();
        end
        check("hold_last", 32'(hitout), 32'(exp));
        check("busy_hold", 32'(busy), 32'd1);
        step();
        check("hitout_clear", 32'(hitout), 32'd0);
        check("busy_clear", 32'(busy), 32'd0);
        swing_n = 1'b1;
        repeat (4) step();
    endtask

    initial begin
        nib_tab = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h4, 4'hA, 4'hD, 4'h6};

        // Reset values
        #12;
        check("rst_hitout", 32'(hitout), 32'd0);
        check("rst_rv", 32'(result_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // LFSR sequence after release, then idle quiet
        for (int k = 0; k < 12; k++) begin
            step();
            check($sformatf("lfsr_nib%0d", k + 1), 32'(dut.lfsr_q[3:0]), 32'(nib_tab[k]));
        end
        repeat (38) step();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_hitout", 32'(hitout), 32'd0);
        check("idle_rv_count", 32'(rv_seen), 32'd0);

        // Window expiry gives out, held for HOLD cycles
        start_pitch();
        push(5'b00001);
        wait_result(WIN, 5'b00001);
        hold_check(5'b00001, 1'b0);

        // Held swing early in the window
        start_pitch();
        swing_result(0, exp_res);
        hold_check(exp_res, 1'b0);
        check("one_evt_count", 32'(rv_seen), 32'(rv_expected));

        // Swing event lands on the expiry cycle: swing wins
        start_pitch();
        swing_result(2, exp_res);
        hold_check(exp_res, 1'b1);

        // Another draw at a different point in the window
        start_pitch();
        swing_result(1, exp_res);
        hold_check(exp_res, 1'b0);

        // Bounces shorter than the debounce never register
        start_pitch();
        push(5'b00001);
        for (int i = 0; i < 18; i++) begin
            swing_n = ((i % 10) < 5) ? 1'b0 : 1'b1;
            step();
        end
        swing_n = 1'b1;
        wait_result(2, 5'b00001);
        hold_check(5'b00001, 1'b0);

        // Swing while idle is ignored
        swing_n = 1'b0;
        repeat (40) step();
        check("idle_swing_busy", 32'(busy), 32'd0);
        check("idle_swing_hitout", 32'(hitout), 32'd0);
        swing_n = 1'b1;
        repeat (5) step();

        // Second pitch_valid during PITCH does not restart the window
        start_pitch();
        push(5'b00001);
        repeat (5) step();
        pitch_valid = 1'b1;
        step();
        pitch_valid = 1'b0;
        wait_result(WIN - 6, 5'b00001);
        hold_check(5'b00001, 1'b0);

        // Reset mid-SHOW clears outputs without a clock edge
        start_pitch();
        push(5'b00001);
        wait_result(WIN, 5'b00001);
        repeat (10) step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_show_hitout", 32'(hitout), 32'd0);
        check("arst_show_busy", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (3) step();

        // Reset mid-PITCH, then a normal pitch
        start_pitch();
        repeat (8) step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_pitch_busy", 32'(busy), 32'd0);
        check("arst_pitch_hitout", 32'(hitout), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        start_pitch();
        swing_result(1, exp_res);
        hold_check(exp_res, 1'b0);

        check("total_results", 32'(rv_seen), 32'(rv_expected));
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
